// File: rtl/tach_period_meter.sv
// Fan tachometer period meter: synchronise, glitch-filter and edge-detect tach_in,
// then count clk_in cycles across PULSES_PER_MEAS rising edges with stall timeout.
`timescale 1ns/1ps
module tach_period_meter #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned FILTER_LEN      = 4,
  parameter int unsigned PULSES_PER_MEAS = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 50_000_000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        enable_in,
  input  logic        tach_in,
  output logic [31:0] period_out,
  output logic        valid_out,
  output logic        stalled_out
);

  localparam int RUN_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int PW    = (PULSES_PER_MEAS > 1) ? $clog2(PULSES_PER_MEAS) : 1;
  localparam logic [RUN_W-1:0] RUN_LAST     = RUN_W'(FILTER_LEN - 1);
  localparam logic [PW-1:0]    PULSE_LAST   = PW'(PULSES_PER_MEAS - 1);
  localparam logic [31:0]      TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 32'd1);
  localparam logic [31:0]      ACC_MAX      = 32'hFFFF_FFFF;

  typedef enum logic [0:0] {ARM = 1'b0, MEASURE = 1'b1} state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   synced;
  logic                   level;
  logic [RUN_W-1:0]       run_cnt;
  logic                   edge_flag;
  state_t                 state;
  logic [31:0]            interval_cnt;
  logic [31:0]            period_acc;
  logic [31:0]            acc_inc;
  logic [PW-1:0]          pulse_cnt;

  assign synced  = sync[SYNC_STAGES-1];
  assign acc_inc = (period_acc == ACC_MAX) ? ACC_MAX : period_acc + 32'd1;

  // Plain flop chain for metastability settling on the asynchronous tach input.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], tach_in};
    end
  end

  // Level changes only after FILTER_LEN consecutive differing samples; a rise is flagged for one cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      level     <= 1'b0;
      run_cnt   <= '0;
      edge_flag <= 1'b0;
    end else begin
      edge_flag <= 1'b0;
      if (synced != level) begin
        if (run_cnt == RUN_LAST) begin
          level     <= synced;
          run_cnt   <= '0;
          edge_flag <= synced;
        end else begin
          run_cnt <= run_cnt + RUN_W'(1);
        end
      end else begin
        run_cnt <= '0;
      end
    end
  end

  // Measurement FSM; an edge takes priority over a coincident timeout.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state        <= ARM;
      interval_cnt <= '0;
      period_acc   <= '0;
      pulse_cnt    <= '0;
      period_out   <= '0;
      valid_out    <= 1'b0;
      stalled_out  <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (!enable_in) begin
        state        <= ARM;
        interval_cnt <= '0;
        period_acc   <= '0;
        pulse_cnt    <= '0;
      end else if (edge_flag) begin
        interval_cnt <= '0;
        case (state)
          ARM: begin
            state      <= MEASURE;
            period_acc <= '0;
            pulse_cnt  <= '0;
          end
          MEASURE: begin
            if (pulse_cnt == PULSE_LAST) begin
              // The closing edge also opens the next measurement.
              period_out  <= acc_inc;
              valid_out   <= 1'b1;
              stalled_out <= 1'b0;
              period_acc  <= '0;
              pulse_cnt   <= '0;
            end else begin
              pulse_cnt  <= pulse_cnt + PW'(1);
              period_acc <= acc_inc;
            end
          end
          default: begin
            state      <= ARM;
            period_acc <= '0;
            pulse_cnt  <= '0;
          end
        endcase
      end else if (interval_cnt == TIMEOUT_LAST) begin
        state        <= ARM;
        interval_cnt <= '0;
        period_acc   <= '0;
        pulse_cnt    <= '0;
        if (!stalled_out) begin
          stalled_out <= 1'b1;
          period_out  <= '0;
          valid_out   <= 1'b1;
        end else begin
          stalled_out <= 1'b1;
        end
      end else begin
        interval_cnt <= interval_cnt + 32'd1;
        period_acc   <= (state == MEASURE) ? acc_inc : '0;
      end
    end
  end

endmodule

// File: tb/tb_tach_period_meter.sv
// Randomised/directed bench for tach_period_meter against an event-time reference model.
`timescale 1ns/1ps
module tb_tach_period_meter;

  localparam int SYNC    = 2;
  localparam int FILT    = 4;
  localparam int PPM     = 2;
  localparam int TIMEOUT = 10000;
  localparam int LAT     = SYNC + FILT + 1;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        tach;
  logic [31:0] period;
  logic        valid;
  logic        stalled;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_strobes = 0;

  // Reference model state: rise times are tracked in cycles, not counters.
  int pend[$];
  bit in_rst;
  bit m_arm;
  bit m_stalled;
  int m_start;
  int m_pulses;
  int m_interval;
  bit exp_v;
  int exp_period;
  bit exp_stalled;

  tach_period_meter #(
    .SYNC_STAGES(SYNC), .FILTER_LEN(FILT), .PULSES_PER_MEAS(PPM), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk_in(clk), .rst_in(rst), .enable_in(enable), .tach_in(tach),
    .period_out(period), .valid_out(valid), .stalled_out(stalled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_arm = 1'b1;
    m_stalled = 1'b0;
    m_start = 0;
    m_pulses = 0;
    m_interval = 0;
    pend.delete();
  endtask

  task automatic tick();
    bit edge_now;
    int tmp;
    @(posedge clk);
    #1;
    cyc++;
    exp_v = 1'b0;
    edge_now = 1'b0;
    if (pend.size() > 0 && pend[0] == cyc) begin
      tmp = pend.pop_front();
      edge_now = 1'b1;
    end
    if (!in_rst) begin
      if (!enable) begin
        m_arm = 1'b1;
        m_interval = 0;
      end else if (edge_now) begin
        m_interval = 0;
        if (m_arm) begin
          m_arm = 1'b0;
          m_start = cyc;
          m_pulses = 0;
        end else begin
          m_pulses++;
          if (m_pulses == PPM) begin
            exp_v = 1'b1;
            exp_period = cyc - m_start;
            exp_stalled = 1'b0;
            m_stalled = 1'b0;
            m_start = cyc;
            m_pulses = 0;
          end
        end
      end else if (m_interval == TIMEOUT - 1) begin
        m_interval = 0;
        m_arm = 1'b1;
        if (!m_stalled) begin
          exp_v = 1'b1;
          exp_period = 0;
          exp_stalled = 1'b1;
          m_stalled = 1'b1;
        end
      end else begin
        m_interval++;
      end
    end
    if (valid === 1'b1) n_strobes++;
    if (valid === 1'b1 || exp_v) begin
      chk("strobe_valid", 32'(valid), 32'(exp_v));
      chk("strobe_period", period, 32'(exp_period));
      chk("strobe_stalled", 32'(stalled), 32'(exp_stalled));
    end
    if (errors >= 20) begin
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rise();
    tach = 1'b1;
    pend.push_back(cyc + LAT);
  endtask

  task automatic run_wave(input int hi, input int lo, input int n, input bit glitch);
    for (int p = 0; p < n; p++) begin
      rise();
      if (glitch) begin
        tick_n(hi / 2); tach = 1'b0; tick_n(2); tach = 1'b1; tick_n(hi - hi / 2 - 2);
      end else begin
        tick_n(hi);
      end
      tach = 1'b0;
      if (glitch) begin
        tick_n(lo / 2); tach = 1'b1; tick_n(2); tach = 1'b0; tick_n(lo - lo / 2 - 2);
      end else begin
        tick_n(lo);
      end
    end
  endtask

  task automatic async_reset();
    tach = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("areset_period", period, 32'd0);
    chk("areset_valid", 32'(valid), 32'd0);
    chk("areset_stalled", 32'(stalled), 32'd0);
    #1 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int s0;
    int rel;
    int first_v;
    rst = 1'b1; enable = 1'b1; tach = 1'b0; in_rst = 1'b1;
    model_reset();
    tick_n(3);
    chk("reset_period", period, 32'd0);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_stalled", 32'(stalled), 32'd0);
    rst = 1'b0; in_rst = 1'b0;
    model_reset();

    // Clean 1000-cycle wave, then the same wave with short glitches.
    s0 = n_strobes;
    run_wave(500, 500, 6, 1'b0);
    chk("clean_strobes", 32'(n_strobes - s0), 32'd2);
    chk("clean_period", period, 32'd2000);
    s0 = n_strobes;
    run_wave(500, 500, 6, 1'b1);
    chk("glitch_strobes", 32'(n_strobes - s0), 32'd3);
    chk("glitch_period", period, 32'd2000);

    // Random periods and duty cycles.
    for (int i = 0; i < 8; i++)
      run_wave($urandom_range(30, 600), $urandom_range(30, 600), 1, 1'($urandom_range(0, 1)));

    // Stall from reset with tach held low.
    async_reset();
    rel = cyc; first_v = -1; s0 = n_strobes;
    for (int i = 0; i < 22000; i++) begin
      tick();
      if (valid === 1'b1 && first_v < 0) first_v = cyc - rel;
    end
    chk("stall_strobes", 32'(n_strobes - s0), 32'd1);
    chk("stall_latency", 32'(first_v), 32'(TIMEOUT));
    chk("stall_level", 32'(stalled), 32'd1);
    chk("stall_period", period, 32'd0);

    // Recovery with a 500-cycle wave.
    run_wave(250, 250, 4, 1'b0);
    chk("recover_stalled", 32'(stalled), 32'd0);
    chk("recover_period", period, 32'd1000);

    // Edge consumed on the very cycle the timeout would fire.
    async_reset();
    rel = cyc;
    tick_n(TIMEOUT - LAT);
    rise();
    tick_n(LAT + 30);
    tach = 1'b0;
    chk("edge_vs_timeout_stalled", 32'(stalled), 32'd0);
    tick_n(470);

    // Enable drop mid-measurement, then asynchronous reset mid-measurement.
    run_wave(500, 500, 4, 1'b0);
    chk("pre_disable_period", period, 32'd2000);
    rise();
    tick_n(300);
    enable = 1'b0;
    s0 = n_strobes;
    tick_n(200);
    tach = 1'b0;
    tick_n(300);
    chk("disable_strobes", 32'(n_strobes - s0), 32'd0);
    chk("disable_period_hold", period, 32'd2000);
    chk("disable_stalled_hold", 32'(stalled), 32'd0);
    enable = 1'b1;
    tick_n(200);
    run_wave(500, 500, 3, 1'b0);
    rise();
    tick_n(300);
    async_reset();
    tick_n(20);
    chk("post_reset_period", period, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
